bin2bcd_seq: RTL



---
 rtl/bin2bcd_seq.sv | 103 ++++++++++
 1 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one shift per clock.
// A start/busy/done handshake launches conversions; bcd/ovf change only when done pulses.
module bin2bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int WORK_W = 4 * DIGITS;
    localparam int CNT_W  = $clog2(BIN_W + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              r_state;
    logic [BIN_W-1:0]    r_bin;
    logic [WORK_W-1:0]   r_work;
    logic                r_sticky;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_busy;
    logic                r_done;
    logic [WORK_W-1:0]   r_bcd;
    logic                r_ovf;

    logic [WORK_W-1:0]   w_adj;
    logic [WORK_W-1:0]   w_shifted;
    logic                w_out_bit;
    logic                w_last;
    logic                w_ovf_next;

    // Each digit is adjusted independently; >=5 keeps the result within 4 bits.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign w_adj[4*gi +: 4] = (r_work[4*gi +: 4] >= 4'd5)
                                    ? (r_work[4*gi +: 4] + 4'd3)
                                    : r_work[4*gi +: 4];
        end
    endgenerate

    assign w_shifted  = {w_adj[WORK_W-2:0], r_bin[BIN_W-1]};
    assign w_out_bit  = w_adj[WORK_W-1];
    assign w_ovf_next = r_sticky | w_out_bit;
    assign w_last     = (r_cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_bin    <= '0;
            r_work   <= '0;
            r_sticky <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_bcd    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_bin    <= bin;
                        r_work   <= '0;
                        r_sticky <= 1'b0;
                        r_cnt    <= CNT_W'(BIN_W);
                        r_busy   <= 1'b1;
                        r_state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_work   <= w_shifted;
                    r_bin    <= r_bin << 1;
                    r_sticky <= w_ovf_next;
                    r_cnt    <= r_cnt - 1'b1;
                    // Final shift publishes the post-shift value directly.
                    if (w_last) begin
                        r_bcd   <= w_shifted;
                        r_ovf   <= w_ovf_next;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign bcd  = r_bcd;
    assign ovf  = r_ovf;

endmodule
